// File: rtl/wb_io_hub_pkg.sv
// Shared constants for the Wishbone I/O hub: FSM encodings, slot-field
// position in the word address, and the counter-width helper.
package wb_io_hub_pkg;

  localparam logic [1:0] IO_ST_IDLE   = 2'd0;
  localparam logic [1:0] IO_ST_ACCESS = 2'd1;
  localparam logic [1:0] IO_ST_ERR    = 2'd2;

  localparam int IO_SLOT_LSB  = 12;
  localparam int IO_SLOT_BITS = 4;

  // Bits needed to hold the value itself (at least one).
  function automatic int get_width(input int value);
    if (value < 1) begin
      return 1;
    end else begin
      return $clog2(value + 1);
    end
  endfunction

endpackage

// File: rtl/wb_io_watchdog.sv
// Per-beat wait counter: clear has priority over enable; expired_o flags the
// last permitted wait cycle (count == TIMEOUT-1).
module wb_io_watchdog
  import wb_io_hub_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_BITS = get_width(TIMEOUT);

  logic [CNT_BITS-1:0] cnt_d;
  logic [CNT_BITS-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_BITS'(TIMEOUT - 1));

endmodule

// File: rtl/wb_io_hub.sv
// Wishbone I/O hub: decodes 4 KB device slots, forwards with zero latency and
// turns unmapped or unanswered beats into a one-cycle error. Optional error log: WB_IO_ERR_LOG_EN.
module wb_io_hub
  import wb_io_hub_pkg::*;
#(
  parameter int DEV_COUNT = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic [31:2]             wbs_addr_i,
  input  logic [2:0]              wbs_cti_i,
  input  logic [1:0]              wbs_bte_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic                    wbs_we_i,
  input  logic [31:0]             wbs_data_i,
  output logic [31:0]             wbs_data_o,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic [DEV_COUNT-1:0]    d_cyc_o,
  output logic [DEV_COUNT-1:0]    d_stb_o,
  output logic [31:2]             d_addr_o,
  output logic [2:0]              d_cti_o,
  output logic [1:0]              d_bte_o,
  output logic [3:0]              d_sel_o,
  output logic                    d_we_o,
  output logic [31:0]             d_data_o,
  input  logic [32*DEV_COUNT-1:0] d_data_i,
  input  logic [DEV_COUNT-1:0]    d_ack_i,
`ifdef WB_IO_ERR_LOG_EN
  input  logic [DEV_COUNT-1:0]    d_err_i,
  output logic                    err_valid_o,
  output logic [31:2]             err_addr_o,
  output logic                    err_timeout_o,
  input  logic                    err_clr_i
`else
  input  logic [DEV_COUNT-1:0]    d_err_i
`endif
);

  logic [1:0]              state_d, state_q;
  logic [IO_SLOT_BITS-1:0] slot_s;
  logic                    slot_valid_s, pass_s, sel_s;
  logic                    dev_ack_s, dev_err_s, resp_s;
  logic [31:0]             dev_data_s;
  logic                    wd_clr_s, wd_en_s, wd_expired_s;

  assign slot_s       = wbs_addr_i[IO_SLOT_LSB +: IO_SLOT_BITS];
  assign slot_valid_s = (32'(slot_s) < 32'(DEV_COUNT));
  // Reset gating keeps every combinational output at zero while wb_rst is high.
  assign pass_s       = !wb_rst && (state_q != IO_ST_ERR);
  assign sel_s        = pass_s && slot_valid_s;

  always_comb begin
    d_cyc_o    = '0;
    d_stb_o    = '0;
    dev_ack_s  = 1'b0;
    dev_err_s  = 1'b0;
    dev_data_s = 32'd0;
    for (int k = 0; k < DEV_COUNT; k++) begin
      if (sel_s && (slot_s == IO_SLOT_BITS'(k))) begin
        d_cyc_o[k] = wbs_cyc_i;
        d_stb_o[k] = wbs_stb_i;
        dev_ack_s  = d_ack_i[k];
        dev_err_s  = d_err_i[k];
        dev_data_s = d_data_i[32*k +: 32];
      end else begin
        d_cyc_o[k] = 1'b0;
        d_stb_o[k] = 1'b0;
      end
    end
  end

  assign resp_s     = dev_ack_s | dev_err_s;
  assign wbs_ack_o  = dev_ack_s;
  assign wbs_data_o = dev_data_s;
  assign wbs_err_o  = dev_err_s | (state_q == IO_ST_ERR);

  assign d_addr_o = pass_s ? wbs_addr_i : '0;
  assign d_cti_o  = pass_s ? wbs_cti_i  : 3'd0;
  assign d_bte_o  = pass_s ? wbs_bte_i  : 2'd0;
  assign d_sel_o  = pass_s ? wbs_sel_i  : 4'd0;
  assign d_we_o   = pass_s ? wbs_we_i   : 1'b0;
  assign d_data_o = pass_s ? wbs_data_i : 32'd0;

  always_comb begin
    state_d  = state_q;
    wd_clr_s = 1'b0;
    wd_en_s  = 1'b0;
    case (state_q)
      IO_ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (slot_valid_s) begin
            state_d  = IO_ST_ACCESS;
            wd_clr_s = resp_s;
            wd_en_s  = !resp_s;
          end else begin
            state_d  = IO_ST_ERR;
            wd_clr_s = 1'b1;
          end
        end else begin
          state_d  = IO_ST_IDLE;
          wd_clr_s = 1'b1;
        end
      end
      IO_ST_ACCESS: begin
        // Abort beats response, response beats timeout.
        if (!wbs_cyc_i) begin
          state_d  = IO_ST_IDLE;
          wd_clr_s = 1'b1;
        end else if (resp_s) begin
          wd_clr_s = 1'b1;
        end else if (wbs_stb_i) begin
          if (wd_expired_s) begin
            state_d  = IO_ST_ERR;
            wd_clr_s = 1'b1;
          end else begin
            wd_en_s = 1'b1;
          end
        end else begin
          wd_en_s = 1'b0;
        end
      end
      IO_ST_ERR: begin
        state_d  = IO_ST_IDLE;
        wd_clr_s = 1'b1;
      end
      default: begin
        state_d  = IO_ST_IDLE;
        wd_clr_s = 1'b1;
      end
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= IO_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  wb_io_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (wb_clk),
    .rst       (wb_rst),
    .clr_i     (wd_clr_s),
    .en_i      (wd_en_s),
    .expired_o (wd_expired_s)
  );

`ifdef WB_IO_ERR_LOG_EN
  logic        err_valid_d, err_valid_q;
  logic [31:2] err_addr_d, err_addr_q;
  logic        err_timeout_d, err_timeout_q;
  logic        err_entry_s;

  assign err_entry_s = (state_d == IO_ST_ERR) && (state_q != IO_ST_ERR);

  // A new error in the same cycle as a clear keeps the new record.
  always_comb begin
    err_valid_d   = err_valid_q;
    err_addr_d    = err_addr_q;
    err_timeout_d = err_timeout_q;
    if (err_entry_s) begin
      err_valid_d   = 1'b1;
      err_addr_d    = wbs_addr_i;
      err_timeout_d = (state_q == IO_ST_ACCESS);
    end else if (err_clr_i) begin
      err_valid_d   = 1'b0;
      err_addr_d    = '0;
      err_timeout_d = 1'b0;
    end else begin
      err_valid_d   = err_valid_q;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      err_valid_q   <= 1'b0;
      err_addr_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      err_valid_q   <= err_valid_d;
      err_addr_q    <= err_addr_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_valid_o   = err_valid_q;
  assign err_addr_o    = err_addr_q;
  assign err_timeout_o = err_timeout_q;
`endif

endmodule

// File: doc/wb_io_hub.md
Name: wb_io_hub

Overview:
- Wishbone I/O hub directly downstream of the bus arbiter's I/O-device slave port (region 0xFFFF0000–0xFFFFFFFF).
- Decodes each access to one of DEV_COUNT device slots of 4 KB each.
- Forwards the cycle to the selected device and muxes its response back.
- A per-beat watchdog converts a missing ack, or an unmapped slot, into a one-cycle bus error so no master can hang the bus.

Parameters:
- DEV_COUNT, 4, number of device slots; legal range 1..16.
- TIMEOUT, 255, maximum cycles a beat may wait for ack/err; legal range 2..65535.
- CNT_BITS, GET_WIDTH(TIMEOUT), watchdog counter width; derived, not overridden.

Ports:
- wb_clk  in  1  wishbone clock.
- wb_rst  in  1  reset: asynchronous, active-high.
- wbs_cyc_i, wbs_stb_i  in  1 each  upstream cycle/strobe.
- wbs_addr_i  in  30 [31:2]  upstream word address.
- wbs_cti_i  in  3; wbs_bte_i  in  2; wbs_sel_i  in  4; wbs_we_i  in  1.
- wbs_data_i  in  32  write data.
- wbs_data_o  out  32  read data.
- wbs_ack_o  out  1  upstream ack.
- wbs_err_o  out  1  upstream err.
- d_cyc_o, d_stb_o  out  DEV_COUNT each  per-device cycle/strobe, one-hot or zero.
- d_addr_o  out  30; d_cti_o  out  3; d_bte_o  out  2; d_sel_o  out  4; d_we_o  out  1; d_data_o  out  32  broadcast to all devices.
- d_data_i  in  32*DEV_COUNT  device read data; slot k at bits [32k+31:32k].
- d_ack_i, d_err_i  in  DEV_COUNT each  device responses.

Behaviour:
- Slot decode: slot = wbs_addr_i[15:12]. Valid when slot < DEV_COUNT. Bits [31:16] are ignored (already decoded upstream).
- FSM states: IDLE, ACCESS, ERR. Reset puts the FSM in IDLE and the counter at 0. All outputs are 0 during and after reset.
- Broadcast outputs (d_addr_o, d_cti_o, d_bte_o, d_sel_o, d_we_o, d_data_o):
  - Combinational copies of the upstream signals when state != ERR.
  - 0 in ERR.
- Device strobes: d_cyc_o[slot] = wbs_cyc_i and d_stb_o[slot] = wbs_stb_i, only when the slot is valid and state != ERR. Devices therefore see a request in the same cycle it arrives (zero added latency).
- Responses:
  - wbs_ack_o = d_ack_i[slot] and wbs_data_o = d_data_i[slot] when the device is selected; otherwise 0.
  - wbs_err_o = d_err_i[slot] OR (state == ERR).
- IDLE:
  - cyc&stb with a valid slot -> ACCESS. The counter loads 1 if no ack/err this cycle; an ack/err this cycle stays in ACCESS with the counter at 0.
  - cyc&stb with an invalid slot -> ERR.
  - Otherwise stay in IDLE.
- ACCESS:
  - ack or err from the device: counter <= 0. The state stays ACCESS while cyc is held, which allows burst beats (cti 010); each beat gets its own timeout window.
  - No response: counter += 1.
  - counter == TIMEOUT-1 with no response this cycle -> ERR.
  - cyc low -> IDLE, counter <= 0 (master abort). Abort takes priority over timeout.
  - stb low with cyc high: counter held, no timeout accrues.
- ERR:
  - wbs_err_o = 1 for exactly one cycle; all device strobes masked.
  - Next state is IDLE and the counter clears.
  - The master must re-present or drop stb; a held stb is re-decoded from IDLE.
- Simultaneous device ack and timeout in the same cycle: the ack wins, no ERR.
- A device ack arriving while in ERR is ignored (masked).
- Address change mid-burst: the slot is re-decoded combinationally each cycle. Masters must not change slot within one cyc; behaviour in that case is undefined but must not lock up.

Optional Feature:
- Macro WB_IO_ERR_LOG_EN.
- When defined, the block adds:
  - Ports err_valid_o (out, 1), err_addr_o (out, 30), err_timeout_o (out, 1), err_clr_i (in, 1).
  - On every entry to ERR, the block latches wbs_addr_i into err_addr_o and sets err_valid_o.
  - err_timeout_o is 1 for a timeout and 0 for an unmapped slot.
  - The error record is sticky until err_clr_i; if clear and a new error occur in the same cycle, the new error wins.
  - All log outputs reset to 0.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Decomposition:
- Shared header (define.vh):
  - State encodings IO_ST_IDLE, IO_ST_ACCESS and IO_ST_ERR.
  - IO_SLOT_LSB = 12 and IO_SLOT_BITS = 4.
- function.vh: GET_WIDTH.
- One natural sub-module, wb_io_watchdog: a counter with clear/enable inputs and an expired output at TIMEOUT-1, parameterised by TIMEOUT.

Test Plan:
- Read, slot 1, device acks after 3 cycles with data 0x12345678 -> wbs_ack_o once, 3 cycles after stb; wbs_data_o = 0x12345678; only d_stb_o[1] high.
- Write to addr 0xFFFF3000 with DEV_COUNT=3 -> no d_stb_o asserted; wbs_err_o high exactly 1 cycle later for 1 cycle; then IDLE.
- TIMEOUT=8, device never acks -> d_stb_o high 8 cycles, then wbs_err_o one cycle, d_stb_o low in that cycle; a log (if enabled) holds the address with err_timeout_o = 1.
- 4-beat burst (cti 010, then 111) to slot 0, device acking every 5 cycles, TIMEOUT=8 -> 4 acks, no err (the counter resets per beat).
- Device ack in exactly cycle TIMEOUT-1 -> ack passed through, no err; and cyc dropped at cycle 4 of a stalled beat -> IDLE, counter 0, no err.
- wb_rst asserted asynchronously mid-ACCESS -> all outputs 0 immediately; after release, a fresh read to slot 2 completes normally.
